// File: rtl/cpu_datapath.sv
// Datapath: 16x16 regfile, ALU, sync data memory, load-stall FSM.
// Ports: control word in (DA/AA/BA/FS/MB/RW/MW/resultSource/IMM/PC); D, Z, N, stall out.
module cpu_datapath #(
  parameter int DMEM_AW = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  DA,
  input  logic [3:0]  AA,
  input  logic [3:0]  BA,
  input  logic [2:0]  FS,
  input  logic        MB,
  input  logic        RW,
  input  logic        MW,
  input  logic [1:0]  resultSource,
  input  logic [15:0] IMM,
  input  logic [15:0] PC,
  output logic [15:0] D,
  output logic        Z,
  output logic        N,
  output logic        stall
);

  localparam int DEPTH = 1 << DMEM_AW;

  typedef enum logic {
    IDLE,
    LOAD_WAIT
  } state_t;

  state_t state, nstate;

  logic [15:0] rf [16];
  logic [15:0] dmem [DEPTH];
  logic [15:0] a, rb, b;
  logic [15:0] alu, wbdata, rdata;
  logic [3:0]  ldda;
  logic        is_load, wb_en, flag_en;

  assign a  = rf[AA];
  assign rb = rf[BA];
  assign b  = MB ? IMM : rb;
  assign D  = a;

  always_comb begin
    alu = 16'h0000;
    unique case (FS)
      3'b000: alu = a + b;
      3'b001: alu = a - b;
      3'b010: alu = a & b;
      3'b011: alu = a | b;
      3'b100: alu = a ^ b;
      3'b101: alu = ~a;
      3'b110: alu = {a[14:0], 1'b0};
      3'b111: alu = {1'b0, a[15:1]};
    endcase
  end

  always_comb begin
    wbdata = alu;
    unique case (resultSource)
      2'b00: wbdata = alu;
      2'b01: wbdata = rdata;
      2'b10: wbdata = IMM;
      2'b11: wbdata = PC + 16'd1;
    endcase
  end

  assign is_load = (state == IDLE) && RW && (resultSource == 2'b01);
  assign wb_en   = (state == IDLE) && RW && (resultSource != 2'b01);
  assign flag_en = (state == IDLE) && RW && (resultSource == 2'b00);
  // gate with reset so stall drops the moment reset is asserted
  assign stall   = is_load && reset;

  always_comb begin
    nstate = state;
    unique case (state)
      IDLE:      if (is_load) nstate = LOAD_WAIT;
      LOAD_WAIT: nstate = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      ldda  <= 4'd0;
      Z     <= 1'b0;
      N     <= 1'b0;
      for (int i = 0; i < 16; i++) rf[i] <= 16'h0000;
    end else begin
      state <= nstate;
      if (is_load) ldda <= DA;
      if (state == LOAD_WAIT) rf[ldda] <= rdata;
      else if (wb_en) rf[DA] <= wbdata;
      if (flag_en) begin
        Z <= (alu == 16'h0000);
        N <= alu[15];
      end
    end
  end

  // memory is not reset; read-first so a same-cycle store does not bypass
  always_ff @(posedge clk) begin
    if (is_load) rdata <= dmem[a[DMEM_AW-1:0]];
    if (reset && state == IDLE && MW) dmem[a[DMEM_AW-1:0]] <= rb;
  end

endmodule
